audio_codec_slave: RTL and testbench
====================================

// Module: audio_codec_slave
// PURPOSE
//  Codec-side end of the left-justified audio serial link; the FPGA acts as bus slave.
//  - Receives externally generated BCLK/LRCK plus serial DAC data, and deserialises it into parallel samples.
//  - Serialises parallel ADC-bound samples onto adcdat_out.
//  - Used for slave-mode codec configurations and as a synthesizable loopback/emulation partner for the master interface.
// PARAMETERS
//  WIDTH        16  bits per channel word, MSB first
//  SYNC_STAGES  2   flops in each input synchroniser (>=2)
// PORTS
//  clk          in   1      system clock
//  reset        in   1      synchronous, active-high
//  bclk_in      in   1      async serial bit clock from master
//  lrck_in      in   1      async word clock; 1 = left, 0 = right
//  dacdat_in    in   1      async serial data from master, changes on BCLK fall
//  adcdat_out   out  1      serial data to master, sampled by master on BCLK rise
//  rx_data      out  WIDTH  last complete received word
//  rx_channel   out  1      channel of rx_data; 1 = left, 0 = right
//  rx_valid     out  1      1-cycle strobe: rx_data/rx_channel updated
//  tx_data      in   WIDTH  sample to write into a TX holding register
//  tx_channel   in   1      target holding register; 1 = left, 0 = right
//  tx_we        in   1      write strobe for tx_data
//  tx_req       out  1      1-cycle strobe: holding reg tx_req_channel consumed
//  tx_req_channel out 1     channel just consumed
//  frame_err    out  1      1-cycle strobe: short word detected at channel boundary
// BEHAVIOUR
//  Reset values:
//  - All outputs 0; holding regs 0; bit counters 0; word_active 0.
//  - Synchroniser flops are cleared to 0.
//  Synchronisation:
//  - bclk, lrck and dacdat each pass through SYNC_STAGES flops.
//  - bclk_s_d (one extra flop) gives rise = bclk_s & ~bclk_s_d and fall = ~bclk_s & bclk_s_d.
//  - BCLK high and low times must each be >= SYNC_STAGES+2 clk (4 clk at defaults).
//  RX, evaluated on each rise:
//  - Boundary (lrck_s != lrck_prev):
//    - shift <= {0.., dacdat_s}; rx_cnt <= 1; lrck_prev <= lrck_s.
//    - If word_active && rx_cnt < WIDTH, pulse frame_err.
//    - Set word_active = 1.
//  - Otherwise, if word_active && rx_cnt < WIDTH: shift in dacdat_s and increment rx_cnt.
//  - Extra bits past WIDTH are ignored.
//  - When rx_cnt reaches WIDTH (including WIDTH=1 on a boundary), on the next clk:
//    - rx_data <= shift and rx_channel <= lrck_prev.
//    - Pulse rx_valid; it pulses exactly once per word.
//  - Before the first boundary after reset, nothing is captured, nothing is flagged, and there is no rx_valid.
//  TX, evaluated on each fall:
//  - If lrck_s != tx_lrck_prev:
//    - tx_shift <= hold[lrck_s]; tx_cnt <= 1; adcdat_out <= hold[lrck_s] MSB.
//    - Pulse tx_req with tx_req_channel = lrck_s.
//    - Update tx_lrck_prev.
//  - Else if tx_cnt < WIDTH: shift left, drive next bit, tx_cnt++.
//  - Else: drive 0 (pad).
//  - adcdat_out is registered and changes only on a fall event.
//  - MSB appears <= SYNC_STAGES+2 clk after the real BCLK fall, so it is stable before the next rise.
//  - Until the first LRCK change after reset, adcdat_out = 0.
//  Holding registers:
//  - tx_we writes hold[tx_channel].
//  - If tx_we hits the register being loaded in the same cycle, the shifter takes the OLD value and the new value is kept for the next frame.
//  - If there is no write between frames, the last value is re-sent.
//  Reset mid-frame:
//  - All state clears.
//  - RX and TX resume at the next LRCK edge with no error flagged.
// TESTING
//  1. Master model, 8-clk BCLK, 16 BCLK/half; send L=16'hA5C3, R=16'h0F0F.
//     -> rx_valid pulses with (1,A5C3), then (0,0F0F), once each.
//  2. hold L=16'h8001, R=16'h7FFE.
//     -> Master captures 8001 on the LRCK-high half and 7FFE on the low half; tx_req pulses with ch 1, then ch 0.
//  3. LRCK toggles after only 10 BCLKs.
//     -> frame_err pulses 1 clk; no rx_valid for that word; the next full word is received normally.
//  4. 20 BCLKs per half, data 16'h1234 followed by 4 junk bits.
//     -> rx_data = 1234, single rx_valid; adcdat_out = 0 for bits 17-20.
//  5. tx_we ch 1 = 16'hBEEF in the same clk as the left load, old hold = 16'h1111.
//     -> This frame sends 1111; the next left frame sends BEEF.
//  6. Assert reset for 3 clk mid-word.
//     -> All outputs 0; no frame_err; the first word after the next LRCK edge is received correctly.

Source files
------------

// File: rtl/audio_codec_slave_if.sv
// Parallel sample-side bus of the audio codec slave.
// Ports (slave view):
//   rx_data/rx_channel/rx_valid       received word, its channel and update strobe
//   tx_data/tx_channel/tx_we          write port of the two TX holding registers
//   tx_req/tx_req_channel             strobe when a holding register is consumed
//   frame_err                         strobe when a short word is detected
interface audio_codec_slave_if #(
   parameter int unsigned WIDTH = 16
);
   logic [WIDTH-1:0] rx_data;
   logic             rx_channel;
   logic             rx_valid;
   logic [WIDTH-1:0] tx_data;
   logic             tx_channel;
   logic             tx_we;
   logic             tx_req;
   logic             tx_req_channel;
   logic             frame_err;

   modport slave (
      output rx_data, rx_channel, rx_valid, tx_req, tx_req_channel, frame_err,
      input  tx_data, tx_channel, tx_we
   );

   modport master (
      input  rx_data, rx_channel, rx_valid, tx_req, tx_req_channel, frame_err,
      output tx_data, tx_channel, tx_we
   );
endinterface

// File: rtl/audio_codec_slave.sv
// Codec-side (slave) end of a left-justified audio serial link.
// Deserialises DAC data clocked by an external BCLK/LRCK into parallel words
// and serialises the two TX holding registers onto adcdat_out.
// Ports:
//   clk, reset     system clock, synchronous active-high reset
//   bclk_in        async bit clock from the master
//   lrck_in        async word clock, 1 = left, 0 = right
//   dacdat_in      async serial data from the master (changes on BCLK fall)
//   adcdat_out     serial data to the master (sampled on BCLK rise)
//   bus            parallel sample bus (slave modport)
module audio_codec_slave #(
   parameter int unsigned WIDTH       = 16,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                bclk_in,
   input  logic                lrck_in,
   input  logic                dacdat_in,
   output logic                adcdat_out,
   audio_codec_slave_if.slave  bus
);

   localparam int unsigned    CW       = $clog2(WIDTH + 1);
   localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
   localparam logic [CW-1:0]  CNT_FULL = CW'(WIDTH);

   // Input synchronisers, all the same depth so edges and levels stay aligned
   logic [SYNC_STAGES-1:0] bclk_sync;
   logic [SYNC_STAGES-1:0] lrck_sync;
   logic [SYNC_STAGES-1:0] dat_sync;
   logic                   bclk_s_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         bclk_sync <= '0;
         lrck_sync <= '0;
         dat_sync  <= '0;
         bclk_s_d  <= 1'b0;
      end else begin
         bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], bclk_in};
         lrck_sync <= {lrck_sync[SYNC_STAGES-2:0], lrck_in};
         dat_sync  <= {dat_sync[SYNC_STAGES-2:0], dacdat_in};
         bclk_s_d  <= bclk_sync[SYNC_STAGES-1];
      end
   end

   logic bclk_s;
   logic lrck_s;
   logic dat_s;
   logic rise;
   logic fall;

   assign bclk_s = bclk_sync[SYNC_STAGES-1];
   assign lrck_s = lrck_sync[SYNC_STAGES-1];
   assign dat_s  = dat_sync[SYNC_STAGES-1];
   assign rise   = bclk_s & ~bclk_s_d;
   assign fall   = ~bclk_s & bclk_s_d;

   // RX deserialiser.
   // rx_armed: the first rise after reset only latches the current LRCK level,
   // so the level the synchroniser settles to is never mistaken for a word
   // boundary and a word cut by reset is never flagged.
   logic [WIDTH-1:0] rx_shift;
   logic [CW-1:0]    rx_cnt;
   logic             lrck_prev;
   logic             word_active;
   logic             rx_armed;
   logic             rx_pend;

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_shift       <= '0;
         rx_cnt         <= '0;
         lrck_prev      <= 1'b0;
         word_active    <= 1'b0;
         rx_armed       <= 1'b0;
         rx_pend        <= 1'b0;
         bus.rx_data    <= '0;
         bus.rx_channel <= 1'b0;
         bus.rx_valid   <= 1'b0;
         bus.frame_err  <= 1'b0;
      end else begin
         bus.rx_valid  <= 1'b0;
         bus.frame_err <= 1'b0;

         // Publish a completed word one clk after its last bit
         if (rx_pend) begin
            bus.rx_data    <= rx_shift;
            bus.rx_channel <= lrck_prev;
            bus.rx_valid   <= 1'b1;
            rx_pend        <= 1'b0;
         end

         if (rise) begin
            if (!rx_armed) begin
               rx_armed  <= 1'b1;
               lrck_prev <= lrck_s;
            end else if (lrck_s != lrck_prev) begin
               rx_shift    <= WIDTH'(dat_s);
               rx_cnt      <= CNT_ONE;
               lrck_prev   <= lrck_s;
               word_active <= 1'b1;
               if (word_active && (rx_cnt < CNT_FULL)) begin
                  bus.frame_err <= 1'b1;
               end
               if (CNT_ONE == CNT_FULL) begin
                  rx_pend <= 1'b1;
               end
            end else if (word_active && (rx_cnt < CNT_FULL)) begin
               rx_shift <= WIDTH'({rx_shift, dat_s});
               rx_cnt   <= rx_cnt + CNT_ONE;
               if ((rx_cnt + CNT_ONE) == CNT_FULL) begin
                  rx_pend <= 1'b1;
               end
            end
         end
      end
   end

   // TX holding registers and serialiser.
   // A write landing in the same clk as a load is seen by the shifter as the
   // old value (non-blocking read) and is kept for the next frame.
   logic [1:0][WIDTH-1:0] hold;
   logic [WIDTH-1:0]      tx_shift;
   logic [WIDTH-1:0]      tx_next;
   logic [CW-1:0]         tx_cnt;
   logic                  tx_lrck_prev;
   logic                  tx_armed;

   assign tx_next = tx_shift << 1;

   always_ff @(posedge clk) begin
      if (reset) begin
         hold               <= '0;
         tx_shift           <= '0;
         tx_cnt             <= '0;
         tx_lrck_prev       <= 1'b0;
         tx_armed           <= 1'b0;
         adcdat_out         <= 1'b0;
         bus.tx_req         <= 1'b0;
         bus.tx_req_channel <= 1'b0;
      end else begin
         bus.tx_req <= 1'b0;

         if (bus.tx_we) begin
            hold[bus.tx_channel] <= bus.tx_data;
         end

         if (fall) begin
            if (!tx_armed) begin
               tx_armed     <= 1'b1;
               tx_lrck_prev <= lrck_s;
               adcdat_out   <= 1'b0;
            end else if (lrck_s != tx_lrck_prev) begin
               tx_shift           <= hold[lrck_s];
               tx_cnt             <= CNT_ONE;
               adcdat_out         <= hold[lrck_s][WIDTH-1];
               tx_lrck_prev       <= lrck_s;
               bus.tx_req         <= 1'b1;
               bus.tx_req_channel <= lrck_s;
            end else if (tx_cnt < CNT_FULL) begin
               tx_shift   <= tx_next;
               tx_cnt     <= tx_cnt + CNT_ONE;
               adcdat_out <= tx_next[WIDTH-1];
            end else begin
               // Slot longer than the word: pad with zeros
               adcdat_out <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_audio_codec_slave.sv
// Self-checking bench for audio_codec_slave: a BCLK/LRCK master model drives
// serial words and captures adcdat_out; expected RX words, TX words and
// tx_req channels go into queues and are compared as the DUT produces them.
module tb_audio_codec_slave;

   localparam int unsigned WIDTH = 16;

   logic clk;
   logic reset;
   logic bclk_in;
   logic lrck_in;
   logic dacdat_in;
   logic adcdat_out;

   audio_codec_slave_if #(.WIDTH(WIDTH)) bus ();

   audio_codec_slave #(.WIDTH(WIDTH), .SYNC_STAGES(2)) dut (
      .clk        (clk),
      .reset      (reset),
      .bclk_in    (bclk_in),
      .lrck_in    (lrck_in),
      .dacdat_in  (dacdat_in),
      .adcdat_out (adcdat_out),
      .bus        (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks;
   int n_fail;
   int fe_count;

   logic [16:0] rx_q[$];
   logic        tx_req_q[$];
   logic [15:0] tx_q[$];
   logic [15:0] mhold[2];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Output monitor, sampled on the falling clk edge
   always @(negedge clk) begin
      if (reset === 1'b0) begin
         if (bus.rx_valid === 1'b1) begin
            if (rx_q.size() == 0) begin
               check("rx_spurious_valid", 32'(rx_q.size()), 32'd1);
            end else begin
               logic [16:0] e;
               e = rx_q.pop_front();
               check("rx_word", 32'({bus.rx_channel, bus.rx_data}), 32'(e));
            end
         end
         if (bus.tx_req === 1'b1) begin
            if (tx_req_q.size() == 0) begin
               check("tx_req_spurious", 32'(tx_req_q.size()), 32'd1);
            end else begin
               logic e;
               e = tx_req_q.pop_front();
               check("tx_req_channel", 32'(bus.tx_req_channel), 32'(e));
            end
         end
         if (bus.frame_err === 1'b1) fe_count++;
      end
   end

   // One BCLK period of 8 clk: fall (drive LRCK/data), 4 clk low, sample, rise
   task automatic bclk_cycle(input logic lr, input logic d, output logic sampled);
      @(negedge clk);
      bclk_in   = 1'b0;
      lrck_in   = lr;
      dacdat_in = d;
      repeat (4) @(negedge clk);
      sampled = adcdat_out;
      bclk_in = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   // flags: [0] expect rx word, [1] expect tx_req, [2] expect full tx capture
   task automatic send_half(input logic lr, input logic [15:0] data, input int nbclk,
                            input logic [2:0] flags);
      logic [15:0] cap;
      logic        s;
      cap = '0;
      if (flags[0]) rx_q.push_back({lr, data});
      if (flags[1]) tx_req_q.push_back(lr);
      if (flags[2]) tx_q.push_back(mhold[lr]);
      for (int i = 0; i < nbclk; i++) begin
         logic d;
         d = (i < 16) ? data[15 - i] : 1'($urandom);
         bclk_cycle(lr, d, s);
         if (i < 16) cap[15 - i] = s;
         else check("tx_pad", 32'(s), 32'd0);
      end
      if (flags[2]) begin
         logic [15:0] e;
         e = tx_q.pop_front();
         check("tx_word", 32'(cap), 32'(e));
      end
   endtask

   task automatic write_hold(input logic ch, input logic [15:0] d);
      @(negedge clk);
      bus.tx_channel = ch;
      bus.tx_data    = d;
      bus.tx_we      = 1'b1;
      mhold[ch]      = d;
      @(negedge clk);
      bus.tx_we = 1'b0;
   endtask

   task automatic settle();
      repeat (20) @(negedge clk);
      check("rx_q_drained", 32'(rx_q.size()), 32'd0);
      check("tx_req_q_drained", 32'(tx_req_q.size()), 32'd0);
   endtask

   task automatic check_outputs_zero();
      check("rst_rx_data", 32'(bus.rx_data), 32'd0);
      check("rst_rx_channel", 32'(bus.rx_channel), 32'd0);
      check("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
      check("rst_tx_req", 32'(bus.tx_req), 32'd0);
      check("rst_tx_req_channel", 32'(bus.tx_req_channel), 32'd0);
      check("rst_frame_err", 32'(bus.frame_err), 32'd0);
      check("rst_adcdat_out", 32'(adcdat_out), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks = 0;
      n_fail   = 0;
      fe_count = 0;
      reset     = 1'b1;
      bclk_in   = 1'b1;
      lrck_in   = 1'b0;
      dacdat_in = 1'b0;
      bus.tx_data    = '0;
      bus.tx_channel = 1'b0;
      bus.tx_we      = 1'b0;
      mhold[0] = '0;
      mhold[1] = '0;

      repeat (5) @(negedge clk);
      check_outputs_zero();
      reset = 1'b0;

      // Let the slave observe the idle LRCK level before the first frame
      send_half(1'b0, 16'h0000, 2, 3'b000);

      // Full-frame RX and TX
      write_hold(1'b1, 16'h8001);
      write_hold(1'b0, 16'h7FFE);
      send_half(1'b1, 16'hA5C3, 16, 3'b111);
      send_half(1'b0, 16'h0F0F, 16, 3'b111);
      settle();
      check("frame_err_count_t1", 32'(fe_count), 32'd0);

      // Short left word: flagged at the next boundary, not received
      send_half(1'b1, 16'hDEAD, 10, 3'b010);
      send_half(1'b0, 16'h5A5A, 16, 3'b111);
      settle();
      check("frame_err_count_t3", 32'(fe_count), 32'd1);

      // Long slots: extra RX bits ignored, TX padded with zeros
      send_half(1'b1, 16'h1234, 20, 3'b111);
      send_half(1'b0, 16'hCAFE, 20, 3'b111);
      settle();

      // Write to the left holding register in the same clk as its load
      write_hold(1'b1, 16'h1111);
      fork
         send_half(1'b1, 16'h4321, 16, 3'b111);
         begin
            repeat (3) @(negedge clk);
            bus.tx_channel = 1'b1;
            bus.tx_data    = 16'hBEEF;
            bus.tx_we      = 1'b1;
            mhold[1]       = 16'hBEEF;
            @(negedge clk);
            bus.tx_we = 1'b0;
         end
      join
      send_half(1'b0, 16'h1357, 16, 3'b111);
      send_half(1'b1, 16'h2468, 16, 3'b111);
      settle();

      // Reset in the middle of a left word
      send_half(1'b0, 16'hFACE, 16, 3'b111);
      fork
         send_half(1'b1, 16'h9999, 16, 3'b010);
         begin
            repeat (64) @(negedge clk);
            reset = 1'b1;
            repeat (2) @(negedge clk);
            check_outputs_zero();
            @(negedge clk);
            reset    = 1'b0;
            mhold[0] = '0;
            mhold[1] = '0;
         end
      join
      send_half(1'b0, 16'h3C5A, 16, 3'b111);
      send_half(1'b1, 16'h6A6A, 16, 3'b111);
      settle();
      check("frame_err_count_t6", 32'(fe_count), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
